// File: rtl/sound_cmd_tx.sv
// sound_cmd_tx: 68000-side transmitter for the sound-command link to the Z80.
//
// The block queues command bytes from the 68K I/O write decode and sends them
// one at a time. For each byte it presents snd_code, raises SNDDT (the Z80
// comm register latches on that rise), waits SETUP_CYC cycles, raises SNDON
// (the Z80 IRQ fires on that rise) and then holds until the Z80 answers with
// an I/O cycle or the ack timeout expires. SNDON/SNDDT then stay low for
// GAP_CYC cycles before the next byte.
//
// Ports:
//   main_clk     in   24MHz system clock
//   nRESET       in   asynchronous active-low reset
//   cmd_wr       in   one-cycle write strobe from the 68K IOWR decode
//   cmd_data     in   command byte
//   cmd_full     out  command FIFO full
//   cmd_count    out  command FIFO occupancy
//   Z80_nIORQ    in   Z80 IORQ, asynchronous; a falling edge is the ack
//   snd_code     out  byte presented to the Z80 comm register
//   SNDDT        out  comm register latch strobe
//   SNDON        out  Z80 IRQ request
//   busy         out  transfer in progress or commands pending
//   timeout_err  out  sticky: a command was abandoned without an ack
//   err_clr      in   clears timeout_err
module sound_cmd_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SETUP_CYC   = 2,
    parameter int GAP_CYC     = 4,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                            main_clk,
    input  logic                            nRESET,
    input  logic                            cmd_wr,
    input  logic [7:0]                      cmd_data,
    output logic                            cmd_full,
    output logic [$clog2(FIFO_DEPTH):0]     cmd_count,
    input  logic                            Z80_nIORQ,
    output logic [7:0]                      snd_code,
    output logic                            SNDDT,
    output logic                            SNDON,
    output logic                            busy,
    output logic                            timeout_err,
    input  logic                            err_clr
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int MAX_A   = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int CNT_MAX = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FIRE,
        WAIT_ACK,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           next_state;

    assign full = (count == OCC_W'(FIFO_DEPTH));
    // A write into a full FIFO is dropped even if a pop happens that cycle.
    assign push = cmd_wr && !full;
    assign pop  = (state == IDLE) && (count != '0);

    // NOTE: storage has no reset; only the pointers and count define
    // which entries are valid, so clearing the array would buy nothing.
    always_ff @(posedge main_clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge main_clk or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ack synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic iorq_meta;
    logic iorq_sync;
    logic iorq_prev;
    logic ack;

    // Reset to the idle-high level so reset release cannot fake an edge.
    always_ff @(posedge main_clk or negedge nRESET) begin
        if (!nRESET) begin
            iorq_meta <= 1'b1;
            iorq_sync <= 1'b1;
            iorq_prev <= 1'b1;
        end else begin
            iorq_meta <= Z80_nIORQ;
            iorq_sync <= iorq_meta;
            iorq_prev <= iorq_sync;
        end
    end

    assign ack = iorq_prev && !iorq_sync;

    // ------------------------------------------------------------------
    // Transfer state machine
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_set;
    logic             snddt_next;
    logic             sndon_next;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (count != '0) next_state = SETUP;
            end
            SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    next_state = FIRE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            FIRE: begin
                next_state = WAIT_ACK;
                cnt_next   = '0;
            end
            WAIT_ACK: begin
                // An ack in the final timeout cycle takes priority.
                if (ack) begin
                    next_state = GAP;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    next_state = GAP;
                    cnt_next   = '0;
                    err_set    = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Strobes are registered from the next state so they change
        // together with the state and never glitch toward the Z80.
        snddt_next = (next_state == SETUP) || (next_state == FIRE) ||
                     (next_state == WAIT_ACK);
        sndon_next = (next_state == FIRE) || (next_state == WAIT_ACK);
    end

    always_ff @(posedge main_clk or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            SNDDT       <= 1'b0;
            SNDON       <= 1'b0;
            snd_code    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            SNDDT <= snddt_next;
            SNDON <= sndon_next;
            // snd_code only changes on a pop, so it stays stable from
            // SETUP through GAP for the byte that raised the IRQ.
            if (pop) snd_code <= mem[rd_ptr];
            if (err_set)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    assign cmd_full  = full;
    assign cmd_count = count;
    assign busy      = (state != IDLE) || (count != '0);

endmodule
